mips_multicycle_controller: RTL and testbench
=============================================

// Module: mips_multicycle_controller
// PURPOSE
//  Control FSM for the multi-cycle MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut/MDR regs).
//  Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction and drives every mux select and write enable.
//  Resolves branch conditions internally, traps on illegal encodings and counts retired instructions.
// PARAMETERS
//  COUNT_W          32  width of retired-instruction counter
//  HALT_ON_ILLEGAL  1   1: illegal opcode/func -> HALT; 0: treat as NOP (back to FETCH, not counted)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous, active-high reset
//  OpCode        in   6        IR[31:26], valid from DECODE onward
//  Func          in   6        IR[5:0]
//  Zero          in   1        ALU zero flag, sampled only in BRANCH
//  PcWrite       out  1        final PC load enable (branch condition already resolved)
//  IorD          out  1        0: mem addr = PC, 1: mem addr = ALUOut
//  MemRead       out  1        memory read strobe
//  MemWrite      out  1        memory write strobe
//  IRWrite       out  1        instruction register load
//  RegDst        out  2        00 rt, 01 rd, 10 $31
//  MemToReg      out  2        00 ALUOut, 01 MDR, 10 PC (link)
//  RegWrite      out  1        register file write
//  AluSrcA       out  1        0 PC, 1 A
//  AluSrcB       out  2        00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//  AluOperation  out  3        000 and, 001 or, 010 add, 110 sub, 111 slt
//  PcSrc         out  2        00 ALU result, 01 ALUOut, 10 {PC[31:28],IR[25:0],2'b00}, 11 A (jr)
//  Halted        out  1        1 while in HALT
//  Retired       out  COUNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset (async): state=FETCH, Retired=0; while rst=1 all outputs forced 0. First fetch in the cycle after release.
//  - Outputs are Moore (decoded from state only), except PcWrite in BRANCH, which uses Zero.
//  - FETCH: IorD=0 MemRead IRWrite AluSrcA=0 AluSrcB=01 add PcSrc=00 PcWrite -> DECODE.
//  - DECODE: AluSrcA=0 AluSrcB=11 add (ALUOut<=branch target). Next state:
//      R-type (000000): add 100000, sub 100010, and 100100, or 100101, slt 101010 -> EXEC_R; jr 001000 -> JR
//      addi 001000 / slti 001010 -> EXEC_I; lw 100011 / sw 101011 -> MEM_ADDR
//      beq 000100 / bne 000101 -> BRANCH; j 000010 -> JUMP; jal 000011 -> JAL; else -> ILLEGAL handling
//  - EXEC_R: AluSrcA=1 AluSrcB=00, AluOperation from Func -> WB_R (RegDst=01 MemToReg=00 RegWrite) -> FETCH.
//  - EXEC_I: AluSrcA=1 AluSrcB=10, add|slt -> WB_I (RegDst=00 MemToReg=00 RegWrite) -> FETCH.
//  - MEM_ADDR: AluSrcA=1 AluSrcB=10 add -> MEM_RD (lw) | MEM_WR (sw).
//    MEM_RD: IorD=1 MemRead -> MEM_WB (RegDst=00 MemToReg=01 RegWrite) -> FETCH. MEM_WR: IorD=1 MemWrite -> FETCH.
//  - BRANCH: AluSrcA=1 AluSrcB=00 sub PcSrc=01; PcWrite = beq ? Zero : ~Zero -> FETCH.
//  - JUMP: PcSrc=10 PcWrite -> FETCH. JAL: PcSrc=10 PcWrite RegDst=10 MemToReg=10 RegWrite
//    (links PC already = old PC+4; regfile write and PC update share the same edge) -> FETCH.
//  - JR: PcSrc=11 PcWrite -> FETCH.
//  - Latency (cycles, FETCH..last): R/addi/slti/sw 4, lw 5, beq/bne/j/jal/jr 3. Strictly one instruction in flight.
//  - Retired += 1 on the clock edge leaving each instruction's final state; wraps 2^COUNT_W-1 -> 0.
//  - Illegal: HALT_ON_ILLEGAL=1 -> HALT (all controls 0, Halted=1, Retired frozen, exits only via rst);
//    HALT_ON_ILLEGAL=0 -> FETCH next cycle, Retired unchanged.
//  - Reset mid-instruction aborts immediately; no partial write may occur after rst rises (outputs gated).
//  - Unreachable state encodings decode to FETCH with all controls 0.
// STRUCTURE
//  - mips_ctrl_pkg: opcode/func constants, ALU-operation codes, PcSrc/AluSrcB/RegDst/MemToReg encodings, state enum.
//  - One sub-module: mips_alu_op_decoder (combinational; state class + OpCode + Func -> AluOperation).
//  - Top: state register, next-state logic, output decode, retired counter.
// TESTING
//  - Reset: rst=1 mid-EXEC_R -> all outputs 0, Retired=0; release -> FETCH with MemRead=IRWrite=PcWrite=1.
//  - add (OpCode 0, Func 100000) -> 4 cycles; WB_R has RegWrite=1 RegDst=01 AluOperation=010; Retired 0->1.
//  - lw/sw -> lw 5 cycles with IorD=1 MemRead in cycle 4; sw 4 cycles with MemWrite=1 only in cycle 4.
//  - beq Zero=1 -> PcWrite=1 PcSrc=01 in cycle 3; beq Zero=0 -> PcWrite=0; bne inverted for both.
//  - jal -> cycle 3: PcSrc=10 RegDst=10 MemToReg=10 RegWrite=1 PcWrite=1; jr (Func 001000) -> PcSrc=11.
//  - OpCode 111111 -> HALT, Halted=1, outputs 0 for 20 cycles; with HALT_ON_ILLEGAL=0 -> FETCH, Retired unchanged.

Source files
------------

// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, function codes,
// ALU operations, datapath mux selects and FSM state codes.
package mips_multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REG    = 2'b11;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_WB_R     = 4'd3;
  localparam logic [3:0] S_EXEC_I   = 4'd4;
  localparam logic [3:0] S_WB_I     = 4'd5;
  localparam logic [3:0] S_MEM_ADDR = 4'd6;
  localparam logic [3:0] S_MEM_RD   = 4'd7;
  localparam logic [3:0] S_MEM_WB   = 4'd8;
  localparam logic [3:0] S_MEM_WR   = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JAL      = 4'd12;
  localparam logic [3:0] S_JR       = 4'd13;
  localparam logic [3:0] S_HALT     = 4'd14;

  // Which source decides the ALU operation in a given state.
  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_ADD,
    CLS_SUB,
    CLS_R,
    CLS_I
  } alu_cls_e;

  function automatic logic is_r_alu(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Controller <-> datapath bundle: IR fields and ALU flag in, every select/enable out.
interface mips_multicycle_controller_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         OpCode;
  logic [5:0]         Func;
  logic               Zero;
  logic               PcWrite;
  logic               IorD;
  logic               MemRead;
  logic               MemWrite;
  logic               IRWrite;
  logic [1:0]         RegDst;
  logic [1:0]         MemToReg;
  logic               RegWrite;
  logic               AluSrcA;
  logic [1:0]         AluSrcB;
  logic [2:0]         AluOperation;
  logic [1:0]         PcSrc;
  logic               Halted;
  logic [COUNT_W-1:0] Retired;

  modport master (
    input  OpCode, Func, Zero,
    output PcWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluOperation, PcSrc, Halted, Retired
  );

  modport slave (
    output OpCode, Func, Zero,
    input  PcWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
           AluSrcA, AluSrcB, AluOperation, PcSrc, Halted, Retired
  );
endinterface

// File: rtl/mips_alu_op_decoder.sv
// Maps the current state class plus IR fields onto the 3-bit ALU operation code.
module mips_alu_op_decoder
  import mips_multicycle_controller_pkg::*;
(
  input  alu_cls_e   i_cls,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_func,
  output logic [2:0] o_alu_op
);

  always_comb begin
    o_alu_op = ALU_AND;
    case (i_cls)
      CLS_ADD: o_alu_op = ALU_ADD;
      CLS_SUB: o_alu_op = ALU_SUB;
      CLS_R: begin
        case (i_func)
          FN_ADD:  o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_SLT:  o_alu_op = ALU_SLT;
          default: o_alu_op = ALU_AND;
        endcase
      end
      CLS_I:   o_alu_op = (i_opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
      default: o_alu_op = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences each instruction, drives all datapath
// controls, resolves branches, traps illegal encodings and counts retirements.
module mips_multicycle_controller
  import mips_multicycle_controller_pkg::*;
#(
  parameter int COUNT_W         = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input logic                           clk,
  input logic                           rst,
  mips_multicycle_controller_if.master  bus
);

  localparam logic [3:0] S_ILLEGAL = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;

  logic [3:0]         r_state;
  logic [3:0]         w_next;
  logic [COUNT_W-1:0] r_retired;
  logic               w_final;
  alu_cls_e           w_cls;
  logic [2:0]         w_alu_op;

  logic       w_pc_write, w_iord, w_mem_read, w_mem_write, w_ir_write;
  logic       w_reg_write, w_src_a, w_halted;
  logic [1:0] w_reg_dst, w_mem_to_reg, w_src_b, w_pc_src;

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.OpCode)
          OP_RTYPE: begin
            if (bus.Func == FN_JR)      w_next = S_JR;
            else if (is_r_alu(bus.Func)) w_next = S_EXEC_R;
            else                         w_next = S_ILLEGAL;
          end
          OP_ADDI, OP_SLTI: w_next = S_EXEC_I;
          OP_LW, OP_SW:     w_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE:   w_next = S_BRANCH;
          OP_J:             w_next = S_JUMP;
          OP_JAL:           w_next = S_JAL;
          default:          w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC_R:   w_next = S_WB_R;
      S_EXEC_I:   w_next = S_WB_I;
      S_MEM_ADDR: w_next = (bus.OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = S_MEM_WB;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (r_state)
      S_WB_R, S_WB_I, S_MEM_WB, S_MEM_WR,
      S_BRANCH, S_JUMP, S_JAL, S_JR: w_final = 1'b1;
      default:                       w_final = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_final) r_retired <= r_retired + COUNT_W'(1);
    end
  end

  // Moore decode; only the branch PC enable looks at the live Zero flag.
  always_comb begin
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = REGDST_RT;
    w_mem_to_reg = M2R_ALUOUT;
    w_reg_write  = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = SRCB_REG;
    w_pc_src     = PCSRC_ALU;
    w_halted     = 1'b0;
    w_cls        = CLS_NONE;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = 1'b1;
        w_src_b    = SRCB_FOUR;
        w_cls      = CLS_ADD;
        w_pc_write = 1'b1;
      end
      S_DECODE: begin
        w_src_b = SRCB_IMMSH2;
        w_cls   = CLS_ADD;
      end
      S_EXEC_R: begin
        w_src_a = 1'b1;
        w_cls   = CLS_R;
      end
      S_WB_R: begin
        w_reg_dst   = REGDST_RD;
        w_reg_write = 1'b1;
        w_cls       = CLS_R;
      end
      S_EXEC_I: begin
        w_src_a = 1'b1;
        w_src_b = SRCB_IMM;
        w_cls   = CLS_I;
      end
      S_WB_I: begin
        w_reg_write = 1'b1;
        w_cls       = CLS_I;
      end
      S_MEM_ADDR: begin
        w_src_a = 1'b1;
        w_src_b = SRCB_IMM;
        w_cls   = CLS_ADD;
      end
      S_MEM_RD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEM_WB: begin
        w_mem_to_reg = M2R_MDR;
        w_reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_BRANCH: begin
        w_src_a    = 1'b1;
        w_cls      = CLS_SUB;
        w_pc_src   = PCSRC_ALUOUT;
        w_pc_write = (bus.OpCode == OP_BEQ) ? bus.Zero : ~bus.Zero;
      end
      S_JUMP: begin
        w_pc_src   = PCSRC_JUMP;
        w_pc_write = 1'b1;
      end
      S_JAL: begin
        w_pc_src     = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_reg_dst    = REGDST_RA;
        w_mem_to_reg = M2R_PC;
        w_reg_write  = 1'b1;
      end
      S_JR: begin
        w_pc_src   = PCSRC_REG;
        w_pc_write = 1'b1;
      end
      S_HALT:  w_halted = 1'b1;
      default: w_cls = CLS_NONE;
    endcase
  end

  mips_alu_op_decoder u_alu_op_decoder (
    .i_cls    (w_cls),
    .i_opcode (bus.OpCode),
    .i_func   (bus.Func),
    .o_alu_op (w_alu_op)
  );

  // Gate with rst so nothing can write while reset is asserted mid-cycle.
  assign bus.PcWrite      = w_pc_write  & ~rst;
  assign bus.IorD         = w_iord      & ~rst;
  assign bus.MemRead      = w_mem_read  & ~rst;
  assign bus.MemWrite     = w_mem_write & ~rst;
  assign bus.IRWrite      = w_ir_write  & ~rst;
  assign bus.RegDst       = w_reg_dst    & {2{~rst}};
  assign bus.MemToReg     = w_mem_to_reg & {2{~rst}};
  assign bus.RegWrite     = w_reg_write & ~rst;
  assign bus.AluSrcA      = w_src_a     & ~rst;
  assign bus.AluSrcB      = w_src_b      & {2{~rst}};
  assign bus.AluOperation = w_alu_op     & {3{~rst}};
  assign bus.PcSrc        = w_pc_src     & {2{~rst}};
  assign bus.Halted       = w_halted    & ~rst;
  assign bus.Retired      = r_retired;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed scoreboard bench: two controllers (halt-on-illegal and skip-illegal with a
// 2-bit counter) share stimulus; expected per-cycle control words are queued and checked.
module tb_mips_multicycle_controller;

  typedef struct packed {
    logic [18:0] ctl;
    logic [31:0] ret;
  } exp_t;

  // {PcWrite,IorD,MemRead,MemWrite,IRWrite,RegDst,MemToReg,RegWrite,AluSrcA,AluSrcB,AluOp,PcSrc,Halted}
  localparam logic [18:0] C_ZERO   = 19'b0;
  localparam logic [18:0] C_FETCH  = {5'b10101, 2'b00, 2'b00, 1'b0, 1'b0, 2'b01, 3'b010, 2'b00, 1'b0};
  localparam logic [18:0] C_DECODE = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b11, 3'b010, 2'b00, 1'b0};
  localparam logic [18:0] C_MADDR  = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, 3'b010, 2'b00, 1'b0};
  localparam logic [18:0] C_MRD    = {5'b01100, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [18:0] C_MWB    = {5'b00000, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [18:0] C_MWR    = {5'b01010, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [18:0] C_JUMP   = {5'b10000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0};
  localparam logic [18:0] C_JAL    = {5'b10000, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 3'b000, 2'b10, 1'b0};
  localparam logic [18:0] C_JR     = {5'b10000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b11, 1'b0};
  localparam logic [18:0] C_HALT   = {5'b00000, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 1'b1};

  localparam logic [5:0] RFN [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [2:0] ROP [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  function automatic logic [18:0] f_exec_r(input logic [2:0] a);
    return {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, a, 2'b00, 1'b0};
  endfunction
  function automatic logic [18:0] f_wb_r(input logic [2:0] a);
    return {5'b00000, 2'b01, 2'b00, 1'b1, 1'b0, 2'b00, a, 2'b00, 1'b0};
  endfunction
  function automatic logic [18:0] f_exec_i(input logic [2:0] a);
    return {5'b00000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b10, a, 2'b00, 1'b0};
  endfunction
  function automatic logic [18:0] f_wb_i(input logic [2:0] a);
    return {5'b00000, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, a, 2'b00, 1'b0};
  endfunction
  function automatic logic [18:0] f_branch(input logic pcw);
    return {pcw, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 3'b110, 2'b01, 1'b0};
  endfunction

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op  = 6'b0;
  logic [5:0] fn  = 6'b0;
  logic       z   = 1'b0;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] ret0   = 0;
  logic [31:0] ret1   = 0;

  mips_multicycle_controller_if #(.COUNT_W(32)) if0 ();
  mips_multicycle_controller_if #(.COUNT_W(2))  if1 ();

  assign if0.OpCode = op;
  assign if0.Func   = fn;
  assign if0.Zero   = z;
  assign if1.OpCode = op;
  assign if1.Func   = fn;
  assign if1.Zero   = z;

  mips_multicycle_controller #(.COUNT_W(32), .HALT_ON_ILLEGAL(1'b1)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  mips_multicycle_controller #(.COUNT_W(2), .HALT_ON_ILLEGAL(1'b0)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each cycle, compare every DUT that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("dut0_ctl", 32'({if0.PcWrite, if0.IorD, if0.MemRead, if0.MemWrite, if0.IRWrite,
                             if0.RegDst, if0.MemToReg, if0.RegWrite, if0.AluSrcA, if0.AluSrcB,
                             if0.AluOperation, if0.PcSrc, if0.Halted}), 32'(e.ctl));
        chk("dut0_retired", if0.Retired, e.ret);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("dut1_ctl", 32'({if1.PcWrite, if1.IorD, if1.MemRead, if1.MemWrite, if1.IRWrite,
                             if1.RegDst, if1.MemToReg, if1.RegWrite, if1.AluSrcA, if1.AluSrcB,
                             if1.AluOperation, if1.PcSrc, if1.Halted}), 32'(e.ctl));
        chk("dut1_retired", 32'(if1.Retired), e.ret);
      end
    end
  end

  task automatic step(input logic [5:0] i_op, input logic [5:0] i_fn, input logic i_z,
                      input logic i_r,
                      input logic en0, input logic [18:0] e0, input logic [31:0] r0,
                      input logic en1, input logic [18:0] e1, input logic [31:0] r1);
    @(posedge clk);
    #1;
    op  = i_op;
    fn  = i_fn;
    z   = i_z;
    rst = i_r;
    if (en0) q0.push_back('{ctl: e0, ret: r0});
    if (en1) q1.push_back('{ctl: e1, ret: r1});
  endtask

  task automatic instr0(input logic [5:0] i_op, input logic [5:0] i_fn, input logic i_z,
                        input int n, input logic [18:0] c2, input logic [18:0] c3,
                        input logic [18:0] c4);
    step(i_op, i_fn, i_z, 1'b0, 1'b1, C_FETCH,  ret0, 1'b0, C_ZERO, 0);
    step(i_op, i_fn, i_z, 1'b0, 1'b1, C_DECODE, ret0, 1'b0, C_ZERO, 0);
    if (n > 2) step(i_op, i_fn, i_z, 1'b0, 1'b1, c2, ret0, 1'b0, C_ZERO, 0);
    if (n > 3) step(i_op, i_fn, i_z, 1'b0, 1'b1, c3, ret0, 1'b0, C_ZERO, 0);
    if (n > 4) step(i_op, i_fn, i_z, 1'b0, 1'b1, c4, ret0, 1'b0, C_ZERO, 0);
    ret0 = ret0 + 1;
  endtask

  initial begin
    int halt_cycles;
    // Held in reset: everything low.
    step(6'h00, 6'h00, 1'b0, 1'b1, 1'b1, C_ZERO, 0, 1'b1, C_ZERO, 0);

    for (int i = 0; i < 5; i++)
      instr0(6'b000000, RFN[i], 1'b0, 4, f_exec_r(ROP[i]), f_wb_r(ROP[i]), C_ZERO);
    instr0(6'b001000, 6'h00, 1'b0, 4, f_exec_i(3'b010), f_wb_i(3'b010), C_ZERO);
    instr0(6'b001010, 6'h00, 1'b0, 4, f_exec_i(3'b111), f_wb_i(3'b111), C_ZERO);
    instr0(6'b100011, 6'h00, 1'b0, 5, C_MADDR, C_MRD, C_MWB);
    instr0(6'b101011, 6'h00, 1'b0, 4, C_MADDR, C_MWR, C_ZERO);
    instr0(6'b000100, 6'h00, 1'b1, 3, f_branch(1'b1), C_ZERO, C_ZERO);
    instr0(6'b000100, 6'h00, 1'b0, 3, f_branch(1'b0), C_ZERO, C_ZERO);
    instr0(6'b000101, 6'h00, 1'b1, 3, f_branch(1'b0), C_ZERO, C_ZERO);
    instr0(6'b000101, 6'h00, 1'b0, 3, f_branch(1'b1), C_ZERO, C_ZERO);
    instr0(6'b000010, 6'h00, 1'b0, 3, C_JUMP, C_ZERO, C_ZERO);
    instr0(6'b000011, 6'h00, 1'b0, 3, C_JAL, C_ZERO, C_ZERO);
    instr0(6'b000000, 6'b001000, 1'b0, 3, C_JR, C_ZERO, C_ZERO);

    // Reset asserted while an add sits in EXEC_R.
    step(6'h00, 6'b100000, 1'b0, 1'b0, 1'b1, C_FETCH,  ret0, 1'b0, C_ZERO, 0);
    step(6'h00, 6'b100000, 1'b0, 1'b0, 1'b1, C_DECODE, ret0, 1'b0, C_ZERO, 0);
    step(6'h00, 6'b100000, 1'b0, 1'b1, 1'b1, C_ZERO, 0, 1'b1, C_ZERO, 0);
    step(6'h00, 6'b100000, 1'b0, 1'b1, 1'b1, C_ZERO, 0, 1'b1, C_ZERO, 0);
    ret0 = 0;
    ret1 = 0;

    // Illegal opcode: dut0 halts, dut1 skips it and keeps running.
    step(6'h3f, 6'h00, 1'b0, 1'b0, 1'b1, C_FETCH,  0, 1'b1, C_FETCH,  0);
    step(6'h3f, 6'h00, 1'b0, 1'b0, 1'b1, C_DECODE, 0, 1'b1, C_DECODE, 0);
    halt_cycles = 0;
    step(6'h00, 6'b100000, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, C_FETCH, ret1);
    step(6'h00, 6'b100000, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, C_DECODE, ret1);
    step(6'h00, 6'b100000, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, f_exec_r(3'b010), ret1);
    step(6'h00, 6'b100000, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, f_wb_r(3'b010), ret1);
    halt_cycles += 4;
    ret1 = ret1 + 1;
    // Three jumps take the 2-bit counter 1 -> 2 -> 3 -> 0.
    for (int k = 0; k < 3; k++) begin
      step(6'b000010, 6'h00, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, C_FETCH,  ret1);
      step(6'b000010, 6'h00, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, C_DECODE, ret1);
      step(6'b000010, 6'h00, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, C_JUMP,   ret1);
      halt_cycles += 3;
      ret1 = (ret1 + 1) % 4;
    end
    step(6'b000010, 6'h00, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b1, C_FETCH, ret1);
    halt_cycles += 1;
    while (halt_cycles < 22) begin
      step(6'h3f, 6'h00, 1'b0, 1'b0, 1'b1, C_HALT, 0, 1'b0, C_ZERO, 0);
      halt_cycles += 1;
    end

    // Only reset leaves HALT.
    step(6'h00, 6'h00, 1'b0, 1'b1, 1'b1, C_ZERO,  0, 1'b1, C_ZERO,  0);
    step(6'h00, 6'h00, 1'b0, 1'b0, 1'b1, C_FETCH, 0, 1'b1, C_FETCH, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drain", 32'(q0.size() + q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
